spi_serializer_param: RTL and testbench

SPI_SERIALIZER_PARAM -- requirements
Module: spi_serializer_param

---
 rtl/spi_ser_pkg.sv | 31 +++
 rtl/spi_serializer_param_edge.sv | 54 +++++
 rtl/spi_serializer_param.sv | 168 ++++++++++++++++
 tb/tb_spi_serializer_param.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ser_pkg.sv
// Shared types and constants for the SPI serializer.
//   state_e : frame sequencer states
//   mode_t  : per-frame settings captured when a load is accepted
//   *_MIN/*_MAX : legal parameter ranges, checked at elaboration
package spi_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TRAIL = 2'd3
  } state_e;

  typedef struct packed {
    logic       cpol;
    logic       cpha;
    logic [2:0] cs_sel;
  } mode_t;

  localparam int DATA_W_MIN  = 1;
  localparam int DATA_W_MAX  = 32;
  localparam int CLK_DIV_MIN = 1;
  localparam int CLK_DIV_MAX = 255;
  localparam int NUM_CS_MIN  = 1;
  localparam int NUM_CS_MAX  = 8;

  // Width of the half-period / lead / trail timers and of the bit counter.
  localparam int CNT_W = 8;
  localparam int BIT_W = 6;

endpackage

// File: rtl/spi_serializer_param_edge.sv
// SPI clock edge generator.
// While en is high, a down-counter expires every CLK_DIV clk cycles; the
// expiries alternate between the leading and the trailing SPI clock edge,
// starting with a leading edge CLK_DIV cycles after en rises.
//   clk, rst  : system clock, async active-high reset
//   en        : run (high for the whole shift phase)
//   lead_stb  : one-cycle strobe, SPI clock leaves its idle level
//   trail_stb : one-cycle strobe, SPI clock returns to its idle level
module spi_edge_gen
  import spi_ser_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic lead_stb,
  output logic trail_stb
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             tc;

  assign tc        = en && (cnt_q == '0);
  assign lead_stb  = tc && !phase_q;
  assign trail_stb = tc && phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      // Preload while idle so the first expiry lands CLK_DIV cycles in.
      cnt_d   = CNT_W'(CLK_DIV - 1);
      phase_d = 1'b0;
    end else if (tc) begin
      cnt_d   = CNT_W'(CLK_DIV - 1);
      phase_d = !phase_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_serializer_param.sv
// Parameterised SPI master serializer: one frame of DATA_W bits per load.
//   state    | meaning
//   IDLE     | waiting for ld; done pulses here for one cycle after a frame
//   LEAD     | CS asserted, SPI clock idle, CLK_DIV cycles
//   SHIFT    | SPI clock toggles every CLK_DIV cycles, DATA_W full periods
//   TRAIL    | SPI clock back at idle, CS still asserted, CLK_DIV cycles
// Ports: clk, rst (async active-high); Data_Register/ld/cs_sel/cpol/cpha
// (frame request, captured on an accepted ld); DataBit/SPI_clk/CS (serial
// bus); busy, done (status).
module spi_serializer_param
  import spi_ser_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int CLK_DIV   = 4,
  parameter int NUM_CS    = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [DATA_W-1:0]                            Data_Register,
  input  logic                                         ld,
  input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cs_sel,
  input  logic                                         cpol,
  input  logic                                         cpha,
  output logic                                         DataBit,
  output logic                                         SPI_clk,
  output logic [NUM_CS-1:0]                            CS,
  output logic                                         busy,
  output logic                                         done
);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX ||
      CLK_DIV < CLK_DIV_MIN || CLK_DIV > CLK_DIV_MAX ||
      NUM_CS < NUM_CS_MIN || NUM_CS > NUM_CS_MAX) begin : g_bad_param
    $error("spi_serializer_param: parameter out of range");
  end

  localparam bit MSB = (MSB_FIRST != 0);

  state_e           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic             dout_q, dout_d;
  logic             sclk_q, sclk_d;     // 1 = SPI clock away from its idle level
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [BIT_W-1:0] bit_q, bit_d;       // trailing edges still to come, minus one
  logic             done_q, done_d;

  logic              lead_stb, trail_stb;
  logic              ld_first, sh_first;
  logic [DATA_W-1:0] ld_rest, sh_rest;

  spi_edge_gen #(.CLK_DIV(CLK_DIV)) u_edge (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q == ST_SHIFT),
    .lead_stb (lead_stb),
    .trail_stb(trail_stb)
  );

  // sh_q holds only the bits not yet presented, so "next bit" is always its
  // outgoing end.
  assign ld_first = MSB ? Data_Register[DATA_W-1] : Data_Register[0];
  assign ld_rest  = MSB ? (Data_Register << 1) : (Data_Register >> 1);
  assign sh_first = MSB ? sh_q[DATA_W-1] : sh_q[0];
  assign sh_rest  = MSB ? (sh_q << 1) : (sh_q >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      sh_q    <= '0;
      dout_q  <= 1'b0;
      sclk_q  <= 1'b0;
      tmr_q   <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      sclk_q  <= sclk_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    sclk_d  = sclk_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ld) begin
          state_d       = ST_LEAD;
          mode_d.cpol   = cpol;
          mode_d.cpha   = cpha;
          mode_d.cs_sel = 3'(cs_sel);
          sclk_d        = 1'b0;
          tmr_d         = CNT_W'(CLK_DIV - 1);
          bit_d         = BIT_W'(DATA_W - 1);
          if (cpha) begin
            // First bit goes out on the first leading edge.
            dout_d = 1'b0;
            sh_d   = Data_Register;
          end else begin
            dout_d = ld_first;
            sh_d   = ld_rest;
          end
        end
      end
      ST_LEAD: begin
        if (tmr_q == '0) state_d = ST_SHIFT;
        else             tmr_d   = tmr_q - 1'b1;
      end
      ST_SHIFT: begin
        if (lead_stb) begin
          sclk_d = 1'b1;
          if (mode_q.cpha) begin
            dout_d = sh_first;
            sh_d   = sh_rest;
          end
        end
        if (trail_stb) begin
          sclk_d = 1'b0;
          if (bit_q == '0) begin
            state_d = ST_TRAIL;
            tmr_d   = CNT_W'(CLK_DIV - 1);
          end else begin
            bit_d = bit_q - 1'b1;
            if (!mode_q.cpha) begin
              dout_d = sh_first;
              sh_d   = sh_rest;
            end
          end
        end
      end
      ST_TRAIL: begin
        if (tmr_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    done    = done_q;
    DataBit = dout_q;
    SPI_clk = mode_q.cpol ^ sclk_q;
    CS      = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if ((state_q != ST_IDLE) && (mode_q.cs_sel == 3'(i))) CS[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_serializer_param.sv
module tb_spi_serializer_param;

  typedef struct {
    int          inst;
    logic [31:0] expcap;
    int          nbits;
    logic [7:0]  cs_exp;
    int          ld_cyc;
    int          lat;
    int          blen;
    logic        cpol;
    logic        cpha;
    bit          abort;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpol = 1'b0, cpha = 1'b0;
  int   cyc = 0;

  logic        ld_a = 1'b0, ld_b = 1'b0, ld_c = 1'b0;
  logic [23:0] data_a = '0, data_b = '0;
  logic [7:0]  data_c = '0;
  logic [0:0]  cs_sel_a = '0, cs_sel_c = '0;
  logic [1:0]  cs_sel_b = '0;

  logic [2:0] dbit, sclk, busy_w, done_w;
  logic [0:0] cs_a, cs_c;
  logic [3:0] cs_b;
  logic [7:0] cs_all [3];

  assign cs_all[0] = {7'h7f, cs_a};
  assign cs_all[1] = {4'hf, cs_b};
  assign cs_all[2] = {7'h7f, cs_c};

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_serializer_param u_a (
    .clk(clk), .rst(rst), .Data_Register(data_a), .ld(ld_a), .cs_sel(cs_sel_a),
    .cpol(cpol), .cpha(cpha), .DataBit(dbit[0]), .SPI_clk(sclk[0]), .CS(cs_a),
    .busy(busy_w[0]), .done(done_w[0]));

  spi_serializer_param #(.NUM_CS(4)) u_b (
    .clk(clk), .rst(rst), .Data_Register(data_b), .ld(ld_b), .cs_sel(cs_sel_b),
    .cpol(cpol), .cpha(cpha), .DataBit(dbit[1]), .SPI_clk(sclk[1]), .CS(cs_b),
    .busy(busy_w[1]), .done(done_w[1]));

  spi_serializer_param #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(0)) u_c (
    .clk(clk), .rst(rst), .Data_Register(data_c), .ld(ld_c), .cs_sel(cs_sel_c),
    .cpol(cpol), .cpha(cpha), .DataBit(dbit[2]), .SPI_clk(sclk[2]), .CS(cs_c),
    .busy(busy_w[2]), .done(done_w[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic fail(input string name, input string what);
    n_chk++;
    $display("FAIL %s: %s", name, what);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] cap [3];
  int          ncap [3], blen [3];
  bit          pbusy [3], psclk [3], cs_bad [3];
  logic        cur_cpol [3], cur_cpha [3];
  logic [7:0]  cur_cs [3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (busy_w[k] && !pbusy[k]) begin
        cap[k] = '0; ncap[k] = 0; blen[k] = 0; cs_bad[k] = 1'b0;
        if (sb.size() == 0) begin
          fail("frame_start", $sformatf("inst %0d started a frame, none expected", k));
          cur_cpol[k] = sclk[k]; cur_cpha[k] = 1'b0; cur_cs[k] = cs_all[k];
        end else begin
          chk("start_inst", k, sb[0].inst);
          chk("start_sclk_idle", sclk[k], sb[0].cpol);
          cur_cpol[k] = sb[0].cpol; cur_cpha[k] = sb[0].cpha; cur_cs[k] = sb[0].cs_exp;
        end
      end
      if (busy_w[k]) begin
        blen[k]++;
        if (cs_all[k] !== cur_cs[k]) cs_bad[k] = 1'b1;
        // Sample edge: leading for cpha=0, trailing for cpha=1.
        if (pbusy[k] && (sclk[k] != psclk[k]) && (sclk[k] == !(cur_cpol[k] ^ cur_cpha[k]))) begin
          cap[k] = {cap[k][30:0], dbit[k]};
          ncap[k]++;
        end
      end
      if (done_w[k]) begin
        if (sb.size() == 0) fail("done_unexpected", $sformatf("inst %0d done with empty scoreboard", k));
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_inst", k, e.inst);
          if (e.abort) fail("done_after_abort", "done pulse on an aborted frame");
          else begin
            chk("data_bits", cap[k], e.expcap);
            chk("bit_count", ncap[k], e.nbits);
            chk("cs_during_busy_ok", {31'b0, !cs_bad[k]}, 1);
            chk("done_latency", cyc - e.ld_cyc, e.lat);
            chk("busy_length", blen[k], e.blen);
            chk("cs_high_at_done", cs_all[k], 8'hff);
          end
        end
      end else if (pbusy[k] && !busy_w[k]) begin
        if (sb.size() == 0) fail("busy_drop", "frame ended with no expectation");
        else begin
          exp_t e;
          e = sb.pop_front();
          if (e.abort) chk("abort_no_done", done_w[k], 0);
          else fail("missing_done", $sformatf("inst %0d busy fell without done", k));
        end
      end
      pbusy[k] = busy_w[k];
      psclk[k] = sclk[k];
    end
  end

  // ---------------- stimulus ----------------
  // Drives ld for one cycle from the current point (caller aligns to #1
  // after a posedge), pushes the expectation, then scrambles the inputs.
  task automatic issue(input int k, input logic [31:0] d, input logic [2:0] sel,
                       input logic pol, input logic pha, input logic [7:0] csx,
                       input logic [31:0] expcap, input bit ab);
    exp_t e;
    cpol = pol; cpha = pha;
    case (k)
      0: begin data_a = d[23:0]; cs_sel_a = sel[0:0]; ld_a = 1'b1; end
      1: begin data_b = d[23:0]; cs_sel_b = sel[1:0]; ld_b = 1'b1; end
      default: begin data_c = d[7:0]; cs_sel_c = sel[0:0]; ld_c = 1'b1; end
    endcase
    e.inst = k; e.expcap = expcap; e.cs_exp = csx; e.ld_cyc = cyc;
    e.nbits = (k == 2) ? 8 : 24;
    e.lat   = (k == 2) ? 19 : 201;
    e.blen  = (k == 2) ? 18 : 200;
    e.cpol = pol; e.cpha = pha; e.abort = ab;
    sb.push_back(e);
    @(posedge clk); #1;
    ld_a = 1'b0; ld_b = 1'b0; ld_c = 1'b0;
    data_a = ~data_a; data_b = ~data_b; data_c = ~data_c;
    cs_sel_a = ~cs_sel_a; cs_sel_b = ~cs_sel_b; cs_sel_c = ~cs_sel_c;
    cpol = ~cpol; cpha = ~cpha;
  endtask

  task automatic wait_done(input int k, input int budget);
    int t = 0;
    while (!done_w[k] && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    chk("wait_done", done_w[k], 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_cs", cs_all[k], 8'hff);
      chk("rst_sclk", sclk[k], 0);
      chk("rst_busy", busy_w[k], 0);
      chk("rst_done", done_w[k], 0);
      chk("rst_dbit", dbit[k], 0);
    end
    idle(3);
    rst = 1'b0;
    idle(2);

    // mode 0, defaults
    issue(0, 32'h9E6D55, 3'd0, 1'b0, 1'b0, 8'hfe, 32'h9E6D55, 1'b0);
    wait_done(0, 300); idle(3);

    // mode 3
    issue(0, 32'h80F0FE, 3'd0, 1'b1, 1'b1, 8'hfe, 32'h80F0FE, 1'b0);
    wait_done(0, 300); idle(3);
    chk("mode3_idle_high", sclk[0], 1);

    // ld while busy is ignored
    issue(0, 32'hA5C3F0, 3'd0, 1'b0, 1'b0, 8'hfe, 32'hA5C3F0, 1'b0);
    idle(48);
    data_a = 24'h123456; cpol = 1'b1; cpha = 1'b1; ld_a = 1'b1;
    idle(1);
    ld_a = 1'b0;
    wait_done(0, 300); idle(3);

    // reset mid-frame
    issue(0, 32'h5A5A5A, 3'd0, 1'b1, 1'b1, 8'hfe, 32'h0, 1'b1);
    idle(99);
    rst = 1'b1;
    #1;
    chk("midrst_cs", cs_all[0], 8'hff);
    chk("midrst_sclk", sclk[0], 0);
    chk("midrst_busy", busy_w[0], 0);
    chk("midrst_done", done_w[0], 0);
    idle(1);
    rst = 1'b0;
    idle(10);

    // first ld after reset, mode 1
    issue(0, 32'h3C3C3C, 3'd0, 1'b0, 1'b1, 8'hfe, 32'h3C3C3C, 1'b0);
    wait_done(0, 300); idle(3);

    // cs_sel out of range: no CS, frame runs
    issue(0, 32'hFFFFFF, 3'd1, 1'b0, 1'b0, 8'hff, 32'hFFFFFF, 1'b0);
    wait_done(0, 300); idle(3);

    // back-to-back on NUM_CS=4, second frame in mode 2
    issue(1, 32'hC0FFEE, 3'd2, 1'b0, 1'b0, 8'hfb, 32'hC0FFEE, 1'b0);
    wait_done(1, 300);
    issue(1, 32'h0F1E2D, 3'd3, 1'b1, 1'b0, 8'hf7, 32'h0F1E2D, 1'b0);
    chk("b2b_no_gap_cs", cs_b, 4'b0111);
    wait_done(1, 300); idle(3);

    // LSB first, 8 bits, CLK_DIV=1 (captured MSB-first, so reversed)
    issue(2, 32'h01, 3'd0, 1'b0, 1'b0, 8'hfe, 32'h80, 1'b0);
    wait_done(2, 50); idle(3);
    issue(2, 32'hB4, 3'd0, 1'b0, 1'b0, 8'hfe, 32'h2D, 1'b0);
    wait_done(2, 50); idle(5);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
